// File: rtl/sdcard_writeback_if.sv
// RAM read port and SD block-write controller port seen by the writeback engine.
// master = writeback engine, slave = RAM / SD controller side.
interface sdcard_writeback_if;
    logic        ram_re;
    logic [24:0] ram_address;
    logic [15:0] ram_rdata;
    logic        ram_rdata_valid;
    logic        sd_wr;
    logic        sd_continue;
    logic [31:0] sd_block_addr;
    logic [7:0]  sd_data;
    logic        sd_busy;
    logic        sd_hndshk_req;
    logic        sd_hndshk_ack;
    logic [15:0] sd_error;

    modport master (
        output ram_re,
        output ram_address,
        input  ram_rdata,
        input  ram_rdata_valid,
        output sd_wr,
        output sd_continue,
        output sd_block_addr,
        output sd_data,
        input  sd_busy,
        input  sd_hndshk_req,
        output sd_hndshk_ack,
        input  sd_error
    );

    modport slave (
        input  ram_re,
        input  ram_address,
        output ram_rdata,
        output ram_rdata_valid,
        input  sd_wr,
        input  sd_continue,
        input  sd_block_addr,
        input  sd_data,
        output sd_busy,
        output sd_hndshk_req,
        input  sd_hndshk_ack,
        output sd_error
    );
endinterface

// File: rtl/sdcard_writeback.sv
// Dumps a RAM word range to an SD card, one 512-byte block per 256 words.
// Each 16-bit word goes out low byte first over the controller byte handshake.
module sdcard_writeback #(
    parameter logic [24:0] START_ADDR = 25'h0000000,
    parameter logic [24:0] WORD_COUNT = 25'h0000100,
    parameter logic        SDHC       = 1'b1
) (
    input  logic                clk50,
    input  logic                reset_n,
    input  logic                start,
    sdcard_writeback_if.master  bus,
    output logic                wb_busy,
    output logic                wb_done,
    output logic                wb_error
);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_INIT,
        FETCH,
        WRBLOCK,
        SENDL_0,
        SENDL_1,
        SENDH_0,
        SENDH_1,
        ADVANCE,
        WAIT_BLK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [24:0] addr;
    logic [24:0] addr_nxt;
    logic [24:0] addr_inc;
    logic [24:0] offset;
    logic [15:0] word;
    logic [15:0] word_nxt;
    logic [7:0]  data;
    logic [7:0]  data_nxt;
    logic [31:0] blk_addr;

    assign addr_inc = addr + 25'd1;
    // Distance from the start keeps the end test correct across a 2^25 wrap.
    assign offset   = addr - START_ADDR;
    assign blk_addr = SDHC ? {15'b0, addr[24:8]}
                           : {6'b0, addr, 1'b0};

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            addr  <= '0;
            word  <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            word  <= word_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        word_nxt  = word;
        data_nxt  = data;
        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = START_ADDR;
                    state_nxt = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (!bus.sd_busy) begin
                    state_nxt = (bus.sd_error == 16'h0) ? FETCH : ERROR;
                end
            end
            FETCH: begin
                if (bus.ram_rdata_valid) begin
                    word_nxt  = bus.ram_rdata;
                    state_nxt = (addr[7:0] == 8'h00) ? WRBLOCK : SENDL_0;
                end
            end
            WRBLOCK: begin
                if (bus.sd_busy) begin
                    state_nxt = SENDL_0;
                end
            end
            // Busy dropping mid-block means the controller cut the block short.
            SENDL_0: begin
                if (!bus.sd_busy) begin
                    state_nxt = ERROR;
                end else if (bus.sd_hndshk_req) begin
                    data_nxt  = word[7:0];
                    state_nxt = SENDL_1;
                end
            end
            SENDL_1: begin
                if (!bus.sd_busy) begin
                    state_nxt = ERROR;
                end else if (!bus.sd_hndshk_req) begin
                    state_nxt = SENDH_0;
                end
            end
            SENDH_0: begin
                if (!bus.sd_busy) begin
                    state_nxt = ERROR;
                end else if (bus.sd_hndshk_req) begin
                    data_nxt  = word[15:8];
                    state_nxt = SENDH_1;
                end
            end
            SENDH_1: begin
                if (!bus.sd_busy) begin
                    state_nxt = ERROR;
                end else if (!bus.sd_hndshk_req) begin
                    state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                addr_nxt  = addr_inc;
                state_nxt = (addr_inc[7:0] == 8'h00) ? WAIT_BLK : FETCH;
            end
            WAIT_BLK: begin
                if (!bus.sd_busy) begin
                    if (bus.sd_error != 16'h0) begin
                        state_nxt = ERROR;
                    end else if (offset >= WORD_COUNT) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ram_re        = (state == FETCH);
    assign bus.ram_address   = addr;
    assign bus.sd_wr         = (state == WRBLOCK);
    assign bus.sd_continue   = (state == WRBLOCK) && (blk_addr != 32'h0);
    assign bus.sd_block_addr = blk_addr;
    assign bus.sd_data       = data;
    assign bus.sd_hndshk_ack = (state == SENDL_1) || (state == SENDH_1);

    assign wb_busy  = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign wb_done  = (state == DONE);
    assign wb_error = (state == ERROR);

endmodule

// File: tb/tb_sdcard_writeback.sv
// Scoreboard bench for sdcard_writeback: behavioural RAM and SD controller.
// Three instances cover the default, two-block SDHC and byte-addressed setups.
module tb_sdcard_writeback;

    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    int          sel     = 0;
    logic [15:0] ram_rdata       = 16'h0;
    logic        ram_rdata_valid = 1'b0;
    logic        sd_busy         = 1'b0;
    logic        sd_hndshk_req   = 1'b0;
    logic [15:0] sd_error        = 16'h0;

    int ram_delay = 0;
    int gap       = 0;
    int drop_at   = -1;
    int n_rd      = 0;
    int n_wr      = 0;
    int n_bytes   = 0;
    int n_tot     = 0;
    int n_chk     = 0;
    int n_pass    = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] blk_q[$];
    logic        cont_q[$];

    sdcard_writeback_if if0();
    sdcard_writeback_if if1();
    sdcard_writeback_if if2();

    assign if0.ram_rdata       = ram_rdata;
    assign if0.ram_rdata_valid = ram_rdata_valid;
    assign if0.sd_busy         = sd_busy;
    assign if0.sd_hndshk_req   = sd_hndshk_req;
    assign if0.sd_error        = sd_error;
    assign if1.ram_rdata       = ram_rdata;
    assign if1.ram_rdata_valid = ram_rdata_valid;
    assign if1.sd_busy         = sd_busy;
    assign if1.sd_hndshk_req   = sd_hndshk_req;
    assign if1.sd_error        = sd_error;
    assign if2.ram_rdata       = ram_rdata;
    assign if2.ram_rdata_valid = ram_rdata_valid;
    assign if2.sd_busy         = sd_busy;
    assign if2.sd_hndshk_req   = sd_hndshk_req;
    assign if2.sd_error        = sd_error;

    logic [2:0] wb_busy_v;
    logic [2:0] wb_done_v;
    logic [2:0] wb_error_v;

    sdcard_writeback u0 (
        .clk50    (clk50),
        .reset_n  (reset_n),
        .start    (start && (sel == 0)),
        .bus      (if0.master),
        .wb_busy  (wb_busy_v[0]),
        .wb_done  (wb_done_v[0]),
        .wb_error (wb_error_v[0])
    );

    sdcard_writeback #(.WORD_COUNT(25'h0000200)) u1 (
        .clk50    (clk50),
        .reset_n  (reset_n),
        .start    (start && (sel == 1)),
        .bus      (if1.master),
        .wb_busy  (wb_busy_v[1]),
        .wb_done  (wb_done_v[1]),
        .wb_error (wb_error_v[1])
    );

    sdcard_writeback #(.START_ADDR(25'h0000100), .SDHC(1'b0)) u2 (
        .clk50    (clk50),
        .reset_n  (reset_n),
        .start    (start && (sel == 2)),
        .bus      (if2.master),
        .wb_busy  (wb_busy_v[2]),
        .wb_done  (wb_done_v[2]),
        .wb_error (wb_error_v[2])
    );

    logic        ram_re;
    logic [24:0] ram_address;
    logic        sd_wr;
    logic        sd_continue;
    logic [31:0] sd_block_addr;
    logic [7:0]  sd_data;
    logic        sd_ack;
    logic        wb_busy;
    logic        wb_done;
    logic        wb_error;

    always_comb begin
        case (sel)
            1: begin
                ram_re        = if1.ram_re;
                ram_address   = if1.ram_address;
                sd_wr         = if1.sd_wr;
                sd_continue   = if1.sd_continue;
                sd_block_addr = if1.sd_block_addr;
                sd_data       = if1.sd_data;
                sd_ack        = if1.sd_hndshk_ack;
            end
            2: begin
                ram_re        = if2.ram_re;
                ram_address   = if2.ram_address;
                sd_wr         = if2.sd_wr;
                sd_continue   = if2.sd_continue;
                sd_block_addr = if2.sd_block_addr;
                sd_data       = if2.sd_data;
                sd_ack        = if2.sd_hndshk_ack;
            end
            default: begin
                ram_re        = if0.ram_re;
                ram_address   = if0.ram_address;
                sd_wr         = if0.sd_wr;
                sd_continue   = if0.sd_continue;
                sd_block_addr = if0.sd_block_addr;
                sd_data       = if0.sd_data;
                sd_ack        = if0.sd_hndshk_ack;
            end
        endcase
        wb_busy  = wb_busy_v[sel[1:0]];
        wb_done  = wb_done_v[sel[1:0]];
        wb_error = wb_error_v[sel[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ramword(input logic [24:0] a);
        return 16'hA500 + a[15:0];
    endfunction

    // RAM: acknowledges each read after ram_delay cycles with a one-cycle pulse.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk50);
            if (!reset_n) begin
                ram_rdata_valid = 1'b0;
                cnt = 0;
            end else if (ram_rdata_valid) begin
                ram_rdata_valid = 1'b0;
            end else if (ram_re) begin
                if (cnt >= ram_delay) begin
                    ram_rdata       = ramword(ram_address);
                    ram_rdata_valid = 1'b1;
                    n_rd++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // SD controller: 512 byte requests per sd_wr, gap idle cycles before each.
    initial begin
        int ph;
        int gc;
        int hold;
        ph = 0; gc = 0; hold = 0;
        forever begin
            @(negedge clk50);
            if (!reset_n) begin
                sd_busy       = 1'b0;
                sd_hndshk_req = 1'b0;
                ph = 0;
            end else begin
                if (ph != 0 && sd_wr) chk("wr_in_block", 32'(sd_wr), 0);
                case (ph)
                    0: if (sd_wr) begin
                        if (blk_q.size() == 0) begin
                            chk("blk_extra", 32'(blk_q.size()), 1);
                        end else begin
                            chk("blk_addr", sd_block_addr, blk_q.pop_front());
                            chk("blk_cont", 32'(sd_continue),
                                32'(cont_q.pop_front()));
                        end
                        n_wr++;
                        n_bytes = 0;
                        sd_busy = 1'b1;
                        gc = 0;
                        ph = 1;
                    end
                    1: if (gc >= gap) begin
                        sd_hndshk_req = 1'b1;
                        ph = 2;
                    end else begin
                        gc++;
                    end
                    2: if (sd_ack) begin
                        if (exp_q.size() == 0)
                            chk("byte_extra", 32'(exp_q.size()), 1);
                        else
                            chk("byte", 32'(sd_data), 32'(exp_q.pop_front()));
                        sd_hndshk_req = 1'b0;
                        n_bytes++;
                        n_tot++;
                        gc = 0;
                        if (n_bytes == drop_at) begin
                            sd_busy = 1'b0;
                            ph = 4;
                        end else if (n_bytes == 512) begin
                            hold = 0;
                            ph = 3;
                        end else begin
                            ph = 1;
                        end
                    end
                    3: if (hold >= 2) begin
                        sd_busy = 1'b0;
                        ph = 0;
                    end else begin
                        hold++;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_outs"}, {11'b0, wb_busy_v, wb_done_v, wb_error_v,
            if0.ram_re, if0.sd_wr, if0.sd_continue, if0.sd_hndshk_ack,
            if1.ram_re, if1.sd_wr, if1.sd_continue, if1.sd_hndshk_ack,
            if2.ram_re, if2.sd_wr, if2.sd_continue, if2.sd_hndshk_ack}, 0);
        chk({tag, "_addr"}, 32'(ram_address), 0);
        chk({tag, "_data"}, 32'(sd_data), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        blk_q.delete();
        cont_q.delete();
        n_rd = 0; n_wr = 0; n_tot = 0;
        repeat (3) @(negedge clk50);
        chk_quiet("rst");
        reset_n = 1'b1;
        @(negedge clk50);
    endtask

    task automatic push_dump(input logic [24:0] sa, input int wc,
                             input logic sdhc);
        logic [24:0] a;
        logic [15:0] w;
        logic [31:0] b;
        for (int i = 0; i < wc; i++) begin
            a = sa + 25'(i);
            w = ramword(a);
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
        end
        for (int k = 0; k < wc / 256; k++) begin
            a = sa + 25'(k * 256);
            b = sdhc ? {15'b0, a[24:8]} : {6'b0, a, 1'b0};
            blk_q.push_back(b);
            cont_q.push_back(b != 32'h0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int lim);
        int c;
        c = 0;
        while (!(wb_done || wb_error) && c < lim) begin
            @(negedge clk50);
            c++;
        end
        chk({tag, "_end"}, 32'(wb_done | wb_error), 1);
    endtask

    task automatic go_dump(input logic [24:0] sa, input int wc,
                           input logic sdhc);
        push_dump(sa, wc, sdhc);
        pulse_start();
        chk("busy_run", 32'(wb_busy), 1);
        wait_end("dump", 30000);
        chk("done", 32'(wb_done), 1);
        chk("error", 32'(wb_error), 0);
        chk("busy_end", 32'(wb_busy), 0);
        chk("bytes_left", 32'(exp_q.size()), 0);
        chk("blks_left", 32'(blk_q.size()), 0);
        chk("ram_reads", 32'(n_rd), 32'(wc));
        chk("sd_wr_cnt", 32'(n_wr), 32'(wc / 256));
        chk("byte_cnt", 32'(n_tot), 32'(2 * wc));
        chk("end_addr", 32'(ram_address), 32'(sa + 25'(wc)));
        pulse_start();
        @(negedge clk50);
        chk("done_hold", 32'(wb_done), 1);
        chk("busy_hold", 32'(wb_busy), 0);
    endtask

    task automatic run_dump(input int s, input logic [24:0] sa, input int wc,
                            input logic sdhc, input int rd, input int gp);
        sel = s;
        ram_delay = rd;
        gap = gp;
        drop_at = -1;
        do_reset();
        go_dump(sa, wc, sdhc);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk50);
        chk_quiet("init");

        run_dump(0, 25'h0, 256, 1'b1, 0, 0);
        run_dump(0, 25'h0, 256, 1'b1, 5, 3);
        run_dump(1, 25'h0, 512, 1'b1, 1, 0);
        run_dump(2, 25'h100, 256, 1'b0, 0, 1);

        sel = 0;
        ram_delay = 0;
        gap = 0;
        do_reset();
        sd_error = 16'h0003;
        pulse_start();
        wait_end("init_err", 50);
        chk("init_err_flag", 32'(wb_error), 1);
        chk("init_err_done", 32'(wb_done), 0);
        chk("init_err_busy", 32'(wb_busy), 0);
        pulse_start();
        repeat (3) @(negedge clk50);
        chk("init_err_hold", 32'(wb_error), 1);
        chk("init_err_wr", 32'(n_wr), 0);
        sd_error = 16'h0;

        do_reset();
        drop_at = 40;
        push_dump(25'h0, 256, 1'b1);
        pulse_start();
        wait_end("drop", 5000);
        chk("drop_err", 32'(wb_error), 1);
        chk("drop_done", 32'(wb_done), 0);
        chk("drop_bytes", 32'(n_tot), 40);

        drop_at = -1;
        ram_delay = 2;
        gap = 1;
        do_reset();
        push_dump(25'h0, 256, 1'b1);
        pulse_start();
        c = 0;
        while (n_tot < 100 && c < 20000) begin
            @(negedge clk50);
            c++;
        end
        chk("mid_reach", 32'(n_tot), 100);
        do_reset();
        go_dump(25'h0, 256, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
